// File: rtl/subtrator_serial_if.sv
// subtrator_serial_if: start/done handshake, operand and result bus for the
// bit-serial subtractor. Values are two's complement bit patterns.
// The overflow signal exists only when OVERFLOW_FLAG_EN is defined.
interface subtrator_serial_if #(
   parameter int BIT = 8
);
   logic           start;
   logic [BIT-1:0] A;
   logic [BIT-1:0] B;
   logic           busy;
   logic           done;
   logic [BIT-1:0] diff;
   logic           negativo;
   logic           par;
   logic           zero;
`ifdef OVERFLOW_FLAG_EN
   logic           overflow;

   modport master (
      output start, A, B,
      input  busy, done, diff, negativo, par, zero, overflow
   );

   modport slave (
      input  start, A, B,
      output busy, done, diff, negativo, par, zero, overflow
   );
`else
   modport master (
      output start, A, B,
      input  busy, done, diff, negativo, par, zero
   );

   modport slave (
      input  start, A, B,
      output busy, done, diff, negativo, par, zero
   );
`endif
endinterface

// File: rtl/subtrator_serial.sv
// subtrator_serial: bit-serial two's complement subtractor, diff = A - B,
// one bit per clock, LSB first, through a single full-subtractor cell and a
// borrow flop. A start accepted in IDLE runs BIT edges in RUN and pulses done
// for one cycle in DONE. Optional macro OVERFLOW_FLAG_EN adds the signed
// overflow flag and the sign-capture flops it needs.
module subtrator_serial #(
   parameter int BIT = 8
) (
   input  logic              clock,
   input  logic              reset,
   subtrator_serial_if.slave bus
);

   localparam int CW = (BIT > 1) ? $clog2(BIT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           borrow_q, borrow_d;
   logic [BIT-1:0] ra_q, ra_d;
   logic [BIT-1:0] rb_q, rb_d;
   logic [BIT-1:0] res_q, res_d;
   logic [BIT-1:0] diff_q, diff_d;
   logic           negativo_q, negativo_d;
   logic           par_q, par_d;
   logic           zero_q, zero_d;
`ifdef OVERFLOW_FLAG_EN
   logic           sign_a_q, sign_a_d;
   logic           sign_b_q, sign_b_d;
   logic           overflow_q, overflow_d;
`endif

   // Full-subtractor cell working on the current LSBs of the operand registers.
   logic a_bit, b_bit, d_bit, borrow_out;
   assign a_bit      = ra_q[0];
   assign b_bit      = rb_q[0];
   assign d_bit      = a_bit ^ b_bit ^ borrow_q;
   assign borrow_out = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);

   // Next-state, datapath shifting and result loading.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the
      // case can leave one unassigned and infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      borrow_d   = borrow_q;
      ra_d       = ra_q;
      rb_d       = rb_q;
      res_d      = res_q;
      diff_d     = diff_q;
      negativo_d = negativo_q;
      par_d      = par_q;
      zero_d     = zero_q;
`ifdef OVERFLOW_FLAG_EN
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      overflow_d = overflow_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               ra_d     = bus.A;
               rb_d     = bus.B;
               borrow_d = 1'b0;
               cnt_d    = '0;
`ifdef OVERFLOW_FLAG_EN
               sign_a_d = bus.A[BIT-1];
               sign_b_d = bus.B[BIT-1];
`endif
               state_d  = RUN;
            end
         end

         RUN: begin
            borrow_d = borrow_out;
            res_d    = {d_bit, res_q[BIT-1:1]};
            ra_d     = ra_q >> 1;
            rb_d     = rb_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // Last bit: publish the completed result; final borrow is dropped.
            if (cnt_q == CW'(BIT - 1)) begin
               diff_d     = res_d;
               negativo_d = res_d[BIT-1];
               par_d      = ~res_d[0];
               zero_d     = (res_d == '0);
`ifdef OVERFLOW_FLAG_EN
               overflow_d = (sign_a_q != sign_b_q) && (res_d[BIT-1] != sign_a_q);
`endif
               state_d    = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and visible-result registers; synchronous reset aborts any operation.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge inputs regardless of statement order.
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         borrow_q   <= 1'b0;
         diff_q     <= '0;
         negativo_q <= 1'b0;
         par_q      <= 1'b0;
         zero_q     <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         overflow_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         borrow_q   <= borrow_d;
         diff_q     <= diff_d;
         negativo_q <= negativo_d;
         par_q      <= par_d;
         zero_q     <= zero_d;
`ifdef OVERFLOW_FLAG_EN
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         overflow_q <= overflow_d;
`endif
      end
   end

   // Operand and partial-result shift registers.
   always_ff @(posedge clock) begin
      // NOTE: these are not reset; they are fully reloaded on acceptance or
      // fully shifted before anything reads them, so a reset adds nothing.
      ra_q  <= ra_d;
      rb_q  <= rb_d;
      res_q <= res_d;
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);
   assign bus.diff     = diff_q;
   assign bus.negativo = negativo_q;
   assign bus.par      = par_q;
   assign bus.zero     = zero_q;
`ifdef OVERFLOW_FLAG_EN
   assign bus.overflow = overflow_q;
`endif

endmodule
